// File: rtl/cog_pkg.sv
// rtl/cog_pkg.sv - shared types and default widths for the CoG segment scheduler
// Contents:
//   DEF_* localparams   default parameter values for the scheduler
//   sched_state_t       scheduler FSM state encoding
package cog_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_ENG    = 4;
    localparam int DEF_PT_WIDTH   = 11;
    localparam int DEF_DROP_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        STREAM,
        DROP,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/cog_rr_picker.sv
// rtl/cog_rr_picker.sv - combinational round-robin picker over free accumulator engines
// Ports:
//   free_vec   in   NUM_ENG  1 = engine may be granted this cycle
//   rr_ptr     in   PTR_W    index where the search starts (wraps past NUM_ENG-1)
//   grant      out  NUM_ENG  one-hot lowest-index free engine at or after rr_ptr
//   grant_idx  out  PTR_W    binary index of the granted engine
//   found      out  1        at least one engine was free
module cog_rr_picker
    import cog_pkg::*;
#(
    parameter int NUM_ENG = DEF_NUM_ENG,
    parameter int PTR_W   = $clog2(NUM_ENG)
) (
    input  logic [NUM_ENG-1:0] free_vec,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_ENG-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               found
);

    int               idx;
    logic [PTR_W-1:0] idx_b;

    // Walk the engines starting at rr_ptr; the first free one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_b     = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_ENG) begin
                idx = idx - NUM_ENG;
            end
            idx_b = PTR_W'(idx);
            if (!found && free_vec[idx_b]) begin
                found        = 1'b1;
                grant[idx_b] = 1'b1;
                grant_idx    = idx_b;
            end
        end
    end

endmodule

// File: rtl/cog_segment_scheduler.sv
// rtl/cog_segment_scheduler.sv - distributes figure segments over round-robin CoG accumulator engines
// Ports:
//   i_sys_clk, i_sys_aresetn              clock, asynchronous active-low reset
//   i_data_image, i_data_valid            pixel stream from the receiver
//   i_start_point                         column of the first segment pixel
//   i_start_of_fig, i_end_of_fig          segment delimiters (qualified by i_data_valid)
//   i_end_of_line, i_end_of_frame         line / frame end pulses
//   i_new_frame                           frame start pulse
//   o_eng_start/valid/last [NUM_ENG]      one-hot per-engine strobes, 1 cycle after the pixel
//   o_eng_data, o_eng_start_point         shared pixel bus and segment column
//   o_eng_eol                             i_end_of_line delayed one cycle, to all engines
//   i_eng_done [NUM_ENG]                  engine finished, becomes free
//   o_frame_done                          1-cycle pulse once the frame is closed and engines idle
//   o_busy_vec                            engine occupancy
//   o_drop_count                          segments dropped this frame (saturating)
module cog_segment_scheduler
    import cog_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_ENG    = DEF_NUM_ENG,
    parameter int PT_WIDTH   = DEF_PT_WIDTH,
    parameter int DROP_W     = DEF_DROP_W
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0] i_data_image,
    input  logic                  i_data_valid,
    input  logic [PT_WIDTH-1:0]   i_start_point,
    input  logic                  i_start_of_fig,
    input  logic                  i_end_of_fig,
    input  logic                  i_end_of_line,
    input  logic                  i_end_of_frame,
    input  logic                  i_new_frame,
    output logic [NUM_ENG-1:0]    o_eng_start,
    output logic [NUM_ENG-1:0]    o_eng_valid,
    output logic [NUM_ENG-1:0]    o_eng_last,
    output logic [DATA_WIDTH-1:0] o_eng_data,
    output logic [PT_WIDTH-1:0]   o_eng_start_point,
    output logic                  o_eng_eol,
    input  logic [NUM_ENG-1:0]    i_eng_done,
    output logic                  o_frame_done,
    output logic [NUM_ENG-1:0]    o_busy_vec,
    output logic [DROP_W-1:0]     o_drop_count
);

    localparam int PTR_W = $clog2(NUM_ENG);

    sched_state_t        state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_ENG-1:0]  cur_eng;

    logic [NUM_ENG-1:0]  busy_after_done;
    logic [NUM_ENG-1:0]  free_vec;
    logic [NUM_ENG-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                found;
    logic [PTR_W-1:0]    rr_next;
    logic [DROP_W-1:0]   drop_inc;
    logic                seg_start;
    logic                seg_end;

    // Done is applied before the grant decision, so an engine freed this
    // very cycle can take the next segment.
    assign busy_after_done = o_busy_vec & ~i_eng_done;
    assign free_vec        = ~busy_after_done;

    assign seg_start = i_start_of_fig & i_data_valid;
    assign seg_end   = i_end_of_fig & i_data_valid;

    assign rr_next  = (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + 1'b1;
    assign drop_inc = (&o_drop_count) ? o_drop_count : o_drop_count + 1'b1;

    cog_rr_picker #(
        .NUM_ENG (NUM_ENG),
        .PTR_W   (PTR_W)
    ) u_picker (
        .free_vec  (free_vec),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            cur_eng           <= '0;
            o_eng_start       <= '0;
            o_eng_valid       <= '0;
            o_eng_last        <= '0;
            o_eng_data        <= '0;
            o_eng_start_point <= '0;
            o_eng_eol         <= 1'b0;
            o_frame_done      <= 1'b0;
            o_busy_vec        <= '0;
            o_drop_count      <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            o_eng_start  <= '0;
            o_eng_valid  <= '0;
            o_eng_last   <= '0;
            o_frame_done <= 1'b0;
            o_eng_eol    <= i_end_of_line;
            o_busy_vec   <= busy_after_done;

            case (state)
                IDLE: begin
                    if (i_new_frame) begin
                        o_drop_count <= '0;
                        state        <= ARMED;
                    end
                end

                ARMED: begin
                    if (i_new_frame) begin
                        state <= ARMED;
                    end else if (seg_start) begin
                        if (found) begin
                            o_busy_vec        <= busy_after_done | grant;
                            o_eng_start       <= grant;
                            o_eng_valid       <= grant;
                            o_eng_data        <= i_data_image;
                            o_eng_start_point <= i_start_point;
                            rr_ptr            <= rr_next;
                            cur_eng           <= grant;
                            if (i_end_of_fig) begin
                                o_eng_last <= grant;
                                state      <= i_end_of_frame ? DRAIN : ARMED;
                            end else begin
                                state <= STREAM;
                            end
                        end else begin
                            o_drop_count <= drop_inc;
                            if (i_end_of_fig) begin
                                state <= i_end_of_frame ? DRAIN : ARMED;
                            end else begin
                                state <= DROP;
                            end
                        end
                    end else if (i_end_of_frame) begin
                        state <= DRAIN;
                    end
                end

                STREAM: begin
                    if (i_new_frame) begin
                        state <= ARMED;
                    end else if (i_data_valid) begin
                        o_eng_valid <= cur_eng;
                        o_eng_data  <= i_data_image;
                        if (seg_end) begin
                            o_eng_last <= cur_eng;
                            state      <= i_end_of_frame ? DRAIN : ARMED;
                        end
                    end
                end

                DROP: begin
                    if (i_new_frame) begin
                        state <= ARMED;
                    end else if (seg_end) begin
                        state <= i_end_of_frame ? DRAIN : ARMED;
                    end
                end

                DRAIN: begin
                    if (i_new_frame) begin
                        state <= ARMED;
                    end else if (o_busy_vec == '0) begin
                        o_frame_done <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    state <= i_new_frame ? ARMED : IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cog_segment_scheduler.sv
// tb/tb_cog_segment_scheduler.sv - scoreboard bench for cog_segment_scheduler
module tb_cog_segment_scheduler;

    localparam int DW  = 8;
    localparam int NE  = 4;
    localparam int PW  = 11;
    localparam int DRW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  i_data_image;
    logic           i_data_valid;
    logic [PW-1:0]  i_start_point;
    logic           i_start_of_fig;
    logic           i_end_of_fig;
    logic           i_end_of_line;
    logic           i_end_of_frame;
    logic           i_new_frame;
    logic [NE-1:0]  o_eng_start;
    logic [NE-1:0]  o_eng_valid;
    logic [NE-1:0]  o_eng_last;
    logic [DW-1:0]  o_eng_data;
    logic [PW-1:0]  o_eng_start_point;
    logic           o_eng_eol;
    logic [NE-1:0]  i_eng_done;
    logic           o_frame_done;
    logic [NE-1:0]  o_busy_vec;
    logic [DRW-1:0] o_drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [NE-1:0] st;
        logic [NE-1:0] vl;
        logic [NE-1:0] ls;
        logic [DW-1:0] d;
        logic [PW-1:0] sp;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];

    cog_segment_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_ENG    (NE),
        .PT_WIDTH   (PW),
        .DROP_W     (DRW)
    ) dut (
        .i_sys_clk         (clk),
        .i_sys_aresetn     (rst_n),
        .i_data_image      (i_data_image),
        .i_data_valid      (i_data_valid),
        .i_start_point     (i_start_point),
        .i_start_of_fig    (i_start_of_fig),
        .i_end_of_fig      (i_end_of_fig),
        .i_end_of_line     (i_end_of_line),
        .i_end_of_frame    (i_end_of_frame),
        .i_new_frame       (i_new_frame),
        .o_eng_start       (o_eng_start),
        .o_eng_valid       (o_eng_valid),
        .o_eng_last        (o_eng_last),
        .o_eng_data        (o_eng_data),
        .o_eng_start_point (o_eng_start_point),
        .o_eng_eol         (o_eng_eol),
        .i_eng_done        (i_eng_done),
        .o_frame_done      (o_frame_done),
        .o_busy_vec        (o_busy_vec),
        .o_drop_count      (o_drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every engine strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && ((o_eng_start | o_eng_valid | o_eng_last) != '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_eng_out start=%b valid=%b last=%b data=0x%0h cyc=%0d",
                         o_eng_start, o_eng_valid, o_eng_last, o_eng_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (o_eng_start !== e.st || o_eng_valid !== e.vl || o_eng_last !== e.ls ||
                    o_eng_data !== e.d || (e.st != '0 && o_eng_start_point !== e.sp) || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL eng_out actual start=%b valid=%b last=%b data=0x%0h sp=%0d cyc=%0d expected start=%b valid=%b last=%b data=0x%0h sp=%0d cyc=%0d",
                             o_eng_start, o_eng_valid, o_eng_last, o_eng_data, o_eng_start_point, cyc,
                             e.st, e.vl, e.ls, e.d, e.sp, e.cyc);
                end
            end
        end
    end

    // One pixel; eng is the hand-chosen engine that should receive it (0 = none).
    task automatic pix(input logic [DW-1:0] d, input logic s, input logic e, input logic ef,
                       input logic [PW-1:0] sp, input logic [NE-1:0] eng);
        exp_t x;
        i_data_image   = d;
        i_data_valid   = 1'b1;
        i_start_of_fig = s;
        i_end_of_fig   = e;
        i_end_of_frame = ef;
        i_start_point  = sp;
        @(posedge clk); #1;
        if (eng != '0) begin
            x.st  = s ? eng : '0;
            x.vl  = eng;
            x.ls  = e ? eng : '0;
            x.d   = d;
            x.sp  = sp;
            x.cyc = cyc;
            exp_q.push_back(x);
        end
        i_data_image   = '0;
        i_data_valid   = 1'b0;
        i_start_of_fig = 1'b0;
        i_end_of_fig   = 1'b0;
        i_end_of_frame = 1'b0;
        i_start_point  = '0;
    endtask

    task automatic ctl(input logic nf, input logic eol, input logic eofr);
        i_new_frame    = nf;
        i_end_of_line  = eol;
        i_end_of_frame = eofr;
        @(posedge clk); #1;
        i_new_frame    = 1'b0;
        i_end_of_line  = 1'b0;
        i_end_of_frame = 1'b0;
    endtask

    task automatic done_pulse(input logic [NE-1:0] m);
        i_eng_done = m;
        @(posedge clk); #1;
        i_eng_done = '0;
    endtask

    // frame_done must pulse exactly once, one cycle after busy_vec reads empty.
    task automatic wait_frame_done(input string name);
        int zc     = -1;
        int fd     = -1;
        int pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (zc < 0 && o_busy_vec == '0) zc = k;
            if (o_frame_done) begin
                pulses++;
                if (fd < 0) fd = k;
            end
            @(posedge clk); #1;
        end
        check({name, "_frame_done_seen"}, 32'(fd >= 0), 32'd1);
        check({name, "_frame_done_latency"}, fd - zc, 32'd1);
        check({name, "_frame_done_width"}, pulses, 32'd1);
    endtask

    logic [NE-1:0] t2_eng [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    initial begin
        rst_n          = 1'b0;
        i_data_image   = '0;
        i_data_valid   = 1'b0;
        i_start_point  = '0;
        i_start_of_fig = 1'b0;
        i_end_of_fig   = 1'b0;
        i_end_of_line  = 1'b0;
        i_end_of_frame = 1'b0;
        i_new_frame    = 1'b0;
        i_eng_done     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_eng_start", o_eng_start, 0);
        check("rst_eng_valid", o_eng_valid, 0);
        check("rst_eng_last", o_eng_last, 0);
        check("rst_eng_data", o_eng_data, 0);
        check("rst_start_point", o_eng_start_point, 0);
        check("rst_eol", o_eng_eol, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_busy", o_busy_vec, 0);
        check("rst_drop", o_drop_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 5-pixel segment at column 100 goes to engine 0.
        ctl(1'b1, 1'b0, 1'b0);
        pix(8'h10, 1'b1, 1'b0, 1'b0, 11'd100, 4'b0001);
        pix(8'h11, 1'b0, 1'b0, 1'b0, 11'd0, 4'b0001);
        pix(8'h12, 1'b0, 1'b0, 1'b0, 11'd0, 4'b0001);
        pix(8'h13, 1'b0, 1'b0, 1'b0, 11'd0, 4'b0001);
        pix(8'h14, 1'b0, 1'b1, 1'b0, 11'd0, 4'b0001);
        check("t1_busy", o_busy_vec, 4'b0001);

        // end_of_line is echoed one cycle later for exactly one cycle.
        i_end_of_line = 1'b1;
        @(posedge clk); #1;
        i_end_of_line = 1'b0;
        check("eol_delayed", o_eng_eol, 1);
        @(posedge clk); #1;
        check("eol_cleared", o_eng_eol, 0);

        ctl(1'b0, 1'b0, 1'b1);
        check("t1_drain_no_done", o_frame_done, 0);
        done_pulse(4'b0001);
        wait_frame_done("t1");

        // 6: reset mid-segment clears every output; next frame restarts at engine 0.
        ctl(1'b1, 1'b0, 1'b0);
        pix(8'h21, 1'b1, 1'b0, 1'b0, 11'd200, 4'b0010);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_start", o_eng_start, 0);
        check("t6_rst_valid", o_eng_valid, 0);
        check("t6_rst_data", o_eng_data, 0);
        check("t6_rst_sp", o_eng_start_point, 0);
        check("t6_rst_busy", o_busy_vec, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: four grants then one drop.
        ctl(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            pix(8'(8'h40 + 16 * j), 1'b1, 1'b0, 1'b0, 11'(300 + j), t2_eng[j]);
            pix(8'(8'h41 + 16 * j), 1'b0, 1'b1, 1'b0, 11'd0, t2_eng[j]);
        end
        check("t2_drop_count", o_drop_count, 1);
        check("t2_busy", o_busy_vec, 4'b1111);

        // 3: freed engine 1 is granted; pointer then sits at 2 (engine 2 beats engine 0).
        done_pulse(4'b0010);
        check("t3_busy_after_done", o_busy_vec, 4'b1101);
        pix(8'h90, 1'b1, 1'b0, 1'b0, 11'd400, 4'b0010);
        pix(8'h91, 1'b0, 1'b1, 1'b0, 11'd0, 4'b0010);
        check("t3_busy_full", o_busy_vec, 4'b1111);
        done_pulse(4'b0101);
        check("t3_busy_two_free", o_busy_vec, 4'b1010);
        pix(8'hA0, 1'b1, 1'b0, 1'b0, 11'd401, 4'b0100);
        pix(8'hA1, 1'b0, 1'b1, 1'b0, 11'd0, 4'b0100);
        check("t3_busy_after_rr", o_busy_vec, 4'b1110);

        // 4: wrap to engine 0, close the frame with busy=0101, then drain.
        done_pulse(4'b0010);
        check("t4_busy_pre", o_busy_vec, 4'b1100);
        pix(8'hB0, 1'b1, 1'b0, 1'b0, 11'd500, 4'b0001);
        i_eng_done = 4'b1000;
        pix(8'hB1, 1'b0, 1'b0, 1'b0, 11'd0, 4'b0001);
        i_eng_done = '0;
        pix(8'hB2, 1'b0, 1'b1, 1'b1, 11'd0, 4'b0001);
        check("t4_busy_drain", o_busy_vec, 4'b0101);
        check("t4_no_done_busy2", o_frame_done, 0);
        done_pulse(4'b0001);
        check("t4_busy_one", o_busy_vec, 4'b0100);
        check("t4_no_done_busy1", o_frame_done, 0);
        done_pulse(4'b0100);
        wait_frame_done("t4");

        // 5: new frame clears drop count; 1-pixel segment gives start and last together.
        check("t5_drop_before", o_drop_count, 1);
        ctl(1'b1, 1'b0, 1'b0);
        check("t5_drop_cleared", o_drop_count, 0);
        pix(8'h55, 1'b1, 1'b1, 1'b0, 11'd7, 4'b0010);
        check("t5_busy", o_busy_vec, 4'b0010);

        // Done and grant in the same cycle: the just-freed engine is taken.
        pix(8'h60, 1'b1, 1'b0, 1'b0, 11'd8, 4'b0100);
        pix(8'h61, 1'b0, 1'b1, 1'b0, 11'd0, 4'b0100);
        pix(8'h70, 1'b1, 1'b1, 1'b0, 11'd9, 4'b1000);
        pix(8'h80, 1'b1, 1'b1, 1'b0, 11'd10, 4'b0001);
        check("t5_busy_full", o_busy_vec, 4'b1111);
        i_eng_done = 4'b0010;
        pix(8'hC0, 1'b1, 1'b1, 1'b0, 11'd11, 4'b0010);
        i_eng_done = '0;
        check("t5_busy_regrant", o_busy_vec, 4'b1111);
        check("t5_drop_none", o_drop_count, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
